mbtrain_point_test_rx: RTL and testbench
========================================

# mbtrain_point_test_rx

Receiver-side point-test engine for MBTRAIN link-speed training. When the link-speed RX controller enables it, it syncs to the incoming mainband pattern and compares each of 16 data lanes against a local LFSR reference. It counts per-lane errors, checks the valid-lane framing, and reports a per-lane pass vector plus a framing-error flag. It then handshakes completion back to the controller, which consumes the results to choose its next sideband response.

## Interface
- COMPARE_CYCLES, 4096: number of compared cycles per test.
- ERR_THRESHOLD, 16: per-lane error count at or above which the lane fails.
- SYNC_TIMEOUT, 8192: maximum cycles spent waiting for the first valid pulse.
- LFSR_SEED, 16'hACE1: reference LFSR seed.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- i_en  in  1  test enable (level) from the link-speed controller.
- i_rx_data  in  16  one received bit per lane per cycle.
- i_rx_valid  in  1  received valid-lane bit.
- o_ack  out  1  test complete; held high until i_en falls.
- o_lanes_result  out  16  bit i = 1 means lane i passed.
- o_valid_framing_error  out  1  valid-lane framing mismatch or sync timeout.

## Operation
- Reset values: o_ack=0, o_lanes_result=16'h0000, o_valid_framing_error=0, state IDLE, all counters 0, LFSR=LFSR_SEED.
- IDLE
  - i_en=1 -> WAIT_SYNC.
  - On that same transition: clear the results, error counters and framing flag; reload the LFSR.
  - The results hold their last values while in IDLE. The controller reads them after dropping i_en.
- WAIT_SYNC
  - i_rx_valid=1 -> that cycle is compare cycle 0; go to COMPARE.
  - The timeout counter reaching SYNC_TIMEOUT-1 -> EVAL with the timeout flag set.
- COMPARE (including cycle 0 above)
  - Per lane, per cycle: a mismatch (i_rx_data[i] != lfsr[i]) increments err_cnt[i]. err_cnt[i] saturates at ERR_THRESHOLD.
  - The LFSR advances once per compare cycle.
  - Framing phase counter runs 0..7, wrapping; phase 0 is compare cycle 0. Expected valid = (phase<4), i.e. pattern 8'hF0 MSB-first.
  - Any valid mismatch sets the sticky framing flag.
  - Compare counter == COMPARE_CYCLES-1 -> EVAL.
- EVAL (1 cycle)
  - o_lanes_result[i] <= (err_cnt[i] < ERR_THRESHOLD).
  - o_valid_framing_error <= framing flag.
  - On timeout: o_lanes_result <= 0 and o_valid_framing_error <= 1.
  - -> DONE.
- DONE: o_ack=1. i_en=0 -> IDLE, and o_ack drops on that transition.
- Abort: i_en=0 in WAIT_SYNC, COMPARE or EVAL -> IDLE next cycle. Results keep their cleared values (0/0) and o_ack never asserts.
- LFSR
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifts toward MSB.
  - Expected bit for lane i = lfsr[i].
- Widths
  - Compare counter: clog2(COMPARE_CYCLES).
  - Error counters: clog2(ERR_THRESHOLD+1).
  - Timeout counter: clog2(SYNC_TIMEOUT).

## Timing
- First i_rx_valid=1 at cycle T -> first compare at T; last compare at T+COMPARE_CYCLES-1.
- EVAL at T+COMPARE_CYCLES.
- o_ack and the results are visible from T+COMPARE_CYCLES+1.
- i_en falling at cycle F -> o_ack=0 from F+1.
- i_en high again in the same cycle it could leave IDLE -> restart with no dead cycle beyond IDLE.
- i_rx_valid and i_rx_data are sampled only in WAIT_SYNC/COMPARE; they are don't-care elsewhere.
- rst has priority over i_en.

## Structure
- Package mbtrain_pkg holds:
  - the state encoding (IDLE, WAIT_SYNC, COMPARE, EVAL, DONE);
  - VALID_FRAME_PATTERN=8'hF0;
  - the LFSR polynomial tap mask.
- Sub-module mbtrain_pt_lfsr contains the seedable 16-bit LFSR, with load and advance inputs.
- The top holds the FSM, counters, the 16-lane compare/accumulate and the result registers.

## Test plan
1. Perfect data: driving lfsr-matched data with valid 11110000 repeating gives o_lanes_result=16'hFFFF, o_valid_framing_error=0, and o_ack at T+COMPARE_CYCLES+1.
2. Lane error: with ERR_THRESHOLD=4, inject 3 errors on lane 2 and 4 on lane 9 -> o_lanes_result=16'hFDFF (lane 2 passes, lane 9 fails).
3. Framing error: flip the valid bit at phase 5 once -> o_valid_framing_error=1 and all lanes pass.
4. Sync timeout: with SYNC_TIMEOUT=32, never assert i_rx_valid -> o_ack at 33 cycles after start, result 16'h0000, framing error 1.
5. Abort: drop i_en mid-COMPARE -> IDLE next cycle, o_ack stays 0, results 0. Re-enable -> a clean test gives 16'hFFFF.
6. Hold and reset: results stay stable after i_en falls; asserting rst in DONE clears o_ack and the results the next cycle.

Source files
------------

// File: rtl/mbtrain_pkg.sv
// Shared types and constants for the MBTRAIN receiver point-test engine.
package mbtrain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_COMPARE   = 3'd2,
    ST_EVAL      = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  localparam logic [7:0]  VALID_FRAME_PATTERN = 8'hF0;
  // x^16+x^14+x^13+x^11+1 -> taps at bits 15,13,12,10
  localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAP_MASK)};
  endfunction

endpackage

// File: rtl/mbtrain_pt_lfsr.sv
// Seedable 16-bit Fibonacci LFSR producing the per-lane reference pattern.
module mbtrain_pt_lfsr
  import mbtrain_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        advance,
  output logic [15:0] lfsr
);

  always_ff @(posedge clk) begin
    if (rst || load) begin
      lfsr <= SEED;
    end else if (advance) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

endmodule

// File: rtl/mbtrain_point_test_rx.sv
// MBTRAIN RX point test: syncs on valid, compares 16 lanes to the LFSR, reports pass vector.
//   state     | meaning
//   IDLE      | results held, waiting for i_en
//   WAIT_SYNC | waiting for first valid pulse (that cycle is compare cycle 0)
//   COMPARE   | per-lane error accumulation and valid framing check
//   EVAL      | one cycle to latch results
//   DONE      | o_ack high until i_en falls
module mbtrain_point_test_rx
  import mbtrain_pkg::*;
#(
  parameter int          COMPARE_CYCLES = 4096,
  parameter int          ERR_THRESHOLD  = 16,
  parameter int          SYNC_TIMEOUT   = 8192,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [15:0] i_rx_data,
  input  logic        i_rx_valid,
  output logic        o_ack,
  output logic [15:0] o_lanes_result,
  output logic        o_valid_framing_error
);

  localparam int CMP_W = $clog2(COMPARE_CYCLES);
  localparam int ERR_W = $clog2(ERR_THRESHOLD + 1);
  localparam int TO_W  = $clog2(SYNC_TIMEOUT);

  localparam logic [CMP_W-1:0] CMP_LAST = CMP_W'(COMPARE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(SYNC_TIMEOUT - 1);
  localparam logic [ERR_W-1:0] ERR_SAT  = ERR_W'(ERR_THRESHOLD);

  state_t            state, state_next;
  logic              start, cmp_fire, to_tick, to_expire, eval;
  logic [CMP_W-1:0]  cmp_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic [ERR_W-1:0]  err_cnt [16];
  logic              framing_err, sync_timeout;
  logic [15:0]       lfsr;
  logic              exp_valid;
  logic [15:0]       lane_pass;

  mbtrain_pt_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (start),
    .advance (cmp_fire),
    .lfsr    (lfsr)
  );

  // Framing phase is the low three bits of the compare count.
  assign exp_valid = VALID_FRAME_PATTERN[3'd7 - cmp_cnt[2:0]];
  assign o_ack     = (state == ST_DONE);

  always_comb begin
    lane_pass = '0;
    for (int i = 0; i < 16; i++) begin
      lane_pass[i] = (err_cnt[i] < ERR_SAT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Dropping i_en anywhere outside IDLE wins over every other transition.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    cmp_fire   = 1'b0;
    to_tick    = 1'b0;
    to_expire  = 1'b0;
    eval       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_en) begin
          start      = 1'b1;
          state_next = ST_WAIT_SYNC;
        end
      end
      ST_WAIT_SYNC: begin
        if (!i_en) begin
          state_next = ST_IDLE;
        end else if (i_rx_valid) begin
          cmp_fire   = 1'b1;
          state_next = ST_COMPARE;
        end else if (to_cnt == TO_LAST) begin
          to_expire  = 1'b1;
          state_next = ST_EVAL;
        end else begin
          to_tick = 1'b1;
        end
      end
      ST_COMPARE: begin
        if (!i_en) begin
          state_next = ST_IDLE;
        end else begin
          cmp_fire = 1'b1;
          if (cmp_cnt == CMP_LAST) begin
            state_next = ST_EVAL;
          end
        end
      end
      ST_EVAL: begin
        if (!i_en) begin
          state_next = ST_IDLE;
        end else begin
          eval       = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!i_en) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_cnt               <= '0;
      to_cnt                <= '0;
      framing_err           <= 1'b0;
      sync_timeout          <= 1'b0;
      o_lanes_result        <= '0;
      o_valid_framing_error <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        err_cnt[i] <= '0;
      end
    end else begin
      if (start) begin
        cmp_cnt               <= '0;
        to_cnt                <= '0;
        framing_err           <= 1'b0;
        sync_timeout          <= 1'b0;
        o_lanes_result        <= '0;
        o_valid_framing_error <= 1'b0;
        for (int i = 0; i < 16; i++) begin
          err_cnt[i] <= '0;
        end
      end
      if (to_tick) begin
        to_cnt <= to_cnt + 1'b1;
      end
      if (to_expire) begin
        sync_timeout <= 1'b1;
      end
      if (cmp_fire) begin
        cmp_cnt <= cmp_cnt + 1'b1;
        if (i_rx_valid != exp_valid) begin
          framing_err <= 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
          if ((i_rx_data[i] != lfsr[i]) && (err_cnt[i] != ERR_SAT)) begin
            err_cnt[i] <= err_cnt[i] + 1'b1;
          end
        end
      end
      if (eval) begin
        if (sync_timeout) begin
          o_lanes_result        <= '0;
          o_valid_framing_error <= 1'b1;
        end else begin
          o_lanes_result        <= lane_pass;
          o_valid_framing_error <= framing_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbtrain_point_test_rx.sv
// Randomized bench for mbtrain_point_test_rx with a schedule-level reference model.
module tb_mbtrain_point_test_rx;

  localparam int          C    = 64;
  localparam int          THR  = 4;
  localparam int          TO   = 32;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst, en, valid;
  logic [15:0] data;
  logic        ack;
  logic [15:0] lanes;
  logic        fe;

  always #5 clk = ~clk;

  mbtrain_point_test_rx #(
    .COMPARE_CYCLES (C),
    .ERR_THRESHOLD  (THR),
    .SYNC_TIMEOUT   (TO),
    .LFSR_SEED      (SEED)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .i_en                  (en),
    .i_rx_data             (data),
    .i_rx_valid            (valid),
    .o_ack                 (ack),
    .o_lanes_result        (lanes),
    .o_valid_framing_error (fe)
  );

  int          n_cmp  = 0;
  int          n_fail = 0;
  bit          chk_en = 1'b0;
  logic        exp_ack;
  logic [15:0] exp_res;
  logic        exp_fe;
  int          lane_errs [16];
  logic [15:0] emask [C];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", {31'd0, ack}, {31'd0, exp_ack});
      check("lanes", {16'd0, lanes}, {16'd0, exp_res});
      check("framing", {31'd0, fe}, {31'd0, exp_fe});
    end
  end

  // Reference word for compare cycle k, straight from the polynomial.
  function automatic logic [15:0] ref_word(input int k);
    logic [15:0] s;
    s = SEED;
    for (int j = 0; j < k; j++) begin
      s = {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    end
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic build_errors();
    for (int k = 0; k < C; k++) emask[k] = '0;
    for (int i = 0; i < 16; i++) begin
      int base;
      base = $urandom_range(0, C - 1);
      for (int j = 0; j < lane_errs[i]; j++) begin
        emask[(base + 7 * j) % C][i] = 1'b1;
      end
    end
  endtask

  // One full test from IDLE; flip_k/abort_k < 0 disable those features.
  task automatic run_test(input int d, input int flip_k, input int abort_k,
                          input int hold, input bit rst_in_done);
    build_errors();
    en = 1'b1; valid = 1'($urandom); data = 16'($urandom);
    step();
    exp_res = '0; exp_fe = 1'b0; exp_ack = 1'b0;
    for (int w = 0; w < d; w++) begin
      valid = 1'b0; data = 16'($urandom);
      step();
    end
    for (int k = 0; k < C; k++) begin
      if (k == abort_k) begin
        en = 1'b0; valid = 1'($urandom); data = 16'($urandom);
        repeat (3) step();
        return;
      end
      data  = ref_word(k) ^ emask[k];
      valid = ((k % 8) < 4) ^ (k == flip_k);
      step();
    end
    valid = 1'($urandom); data = 16'($urandom);
    step();
    for (int i = 0; i < 16; i++) exp_res[i] = (lane_errs[i] < THR);
    exp_fe  = (flip_k >= 0);
    exp_ack = 1'b1;
    for (int h = 0; h < hold; h++) begin
      valid = 1'($urandom); data = 16'($urandom);
      step();
    end
    if (rst_in_done) begin
      rst = 1'b1; en = 1'b0;
      step();
      exp_ack = 1'b0; exp_res = '0; exp_fe = 1'b0;
      rst = 1'b0;
      step();
    end else begin
      en = 1'b0;
      step();
      exp_ack = 1'b0;
      repeat (2) step();
    end
  endtask

  task automatic clear_errs();
    for (int i = 0; i < 16; i++) lane_errs[i] = 0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; valid = 1'b0; data = '0;
    exp_ack = 1'b0; exp_res = '0; exp_fe = 1'b0;
    step();
    chk_en = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    step();

    check("ref_lfsr_1", {16'd0, ref_word(1)}, 32'h59C3);

    // perfect data
    clear_errs();
    run_test(3, -1, -1, 2, 1'b0);
    check("t1_lanes", {16'd0, lanes}, 32'hFFFF);
    check("t1_fe", {31'd0, fe}, 32'd0);

    // lane errors around the threshold
    clear_errs();
    lane_errs[2] = 3; lane_errs[9] = 4;
    run_test(0, -1, -1, 1, 1'b0);
    check("t2_lanes", {16'd0, lanes}, 32'hFDFF);

    // framing flip at phase 5
    clear_errs();
    run_test(5, 5, -1, 0, 1'b0);
    check("t3_lanes", {16'd0, lanes}, 32'hFFFF);
    check("t3_fe", {31'd0, fe}, 32'd1);

    // sync timeout: ack exactly TO+1 cycles after entering WAIT_SYNC
    en = 1'b1; valid = 1'b0; data = 16'($urandom);
    step();
    exp_res = '0; exp_fe = 1'b0; exp_ack = 1'b0;
    for (int w = 0; w < TO; w++) begin
      valid = 1'b0; data = 16'($urandom);
      step();
    end
    valid = 1'($urandom);
    step();
    exp_fe = 1'b1; exp_ack = 1'b1;
    step();
    check("t4_lanes", {16'd0, lanes}, 32'h0000);
    check("t4_fe", {31'd0, fe}, 32'd1);
    en = 1'b0;
    step();
    exp_ack = 1'b0;
    step();

    // abort mid-compare, then a clean rerun
    clear_errs();
    run_test(2, -1, 20, 0, 1'b0);
    check("t5_abort_lanes", {16'd0, lanes}, 32'h0000);
    check("t5_abort_ack", {31'd0, ack}, 32'd0);
    run_test(1, -1, -1, 1, 1'b0);
    check("t5_rerun_lanes", {16'd0, lanes}, 32'hFFFF);

    // reset while in DONE
    clear_errs();
    lane_errs[0] = 6;
    run_test(4, 9, -1, 2, 1'b1);
    check("t6_rst_lanes", {16'd0, lanes}, 32'h0000);
    check("t6_rst_ack", {31'd0, ack}, 32'd0);

    // randomized runs
    for (int r = 0; r < 10; r++) begin
      for (int i = 0; i < 16; i++) begin
        lane_errs[i] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
      end
      run_test(int'($urandom_range(0, 20)),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, C - 1)) : -1,
               ($urandom_range(0, 5) == 0) ? int'($urandom_range(5, C - 2)) : -1,
               int'($urandom_range(0, 3)), 1'($urandom_range(0, 4) == 0));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
